// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Holds FSM states, opcodes, datapath select codes and the decode bundle.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_EXEC   = 4'd3;
    localparam state_t S_MEM    = 4'd4;
    localparam state_t S_WB     = 4'd5;
    localparam state_t S_BRANCH = 4'd6;
    localparam state_t S_JUMP   = 4'd7;
    localparam state_t S_HALT   = 4'd8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_FUNCT = 3'd4;

    localparam logic [1:0] A_PC     = 2'd0;
    localparam logic [1:0] A_RS1    = 2'd1;
    localparam logic [1:0] A_OLD_PC = 2'd2;
    localparam logic [1:0] A_ZERO   = 2'd3;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU_R = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_ALU   = 2'd2;
    localparam logic [1:0] WB_PC4   = 2'd3;

    typedef struct packed {
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_r;
        logic is_addi;
        logic is_lui;
        logic is_jal;
        logic is_illegal;
    } dec_t;

    function automatic logic is_mem_op(input dec_t d);
        return d.is_lw | d.is_sw;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct classification of the instruction register.
// Ports: instr (IR contents) in, cls (one-hot instruction class) out.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        cls
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       r_ok;
    logic       unused_bits;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Register fields are irrelevant to classification.
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // add/sub share funct3 000; and/or need funct7 of zero.
    assign r_ok = (f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000))
               || (f3 == 3'b110 && f7 == 7'b0000000)
               || (f3 == 3'b111 && f7 == 7'b0000000);

    assign cls.is_lw   = (opc == OP_LOAD)   && (f3 == 3'b010);
    assign cls.is_sw   = (opc == OP_STORE)  && (f3 == 3'b010);
    assign cls.is_beq  = (opc == OP_BRANCH) && (f3 == 3'b000);
    assign cls.is_r    = (opc == OP_REG)    && r_ok;
    assign cls.is_addi = (opc == OP_IMM)    && (f3 == 3'b000);
    assign cls.is_lui  = (opc == OP_LUI);
    assign cls.is_jal  = (opc == OP_JAL);

    assign cls.is_illegal = ~(cls.is_lw | cls.is_sw | cls.is_beq | cls.is_r
                            | cls.is_addi | cls.is_lui | cls.is_jal);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM with shared memory port arbitration.
// Ports: clk/rst_n, instr/zero/mem_ack in; datapath selects, enables,
//        memory request, retire pulse/counter and sticky illegal out.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_src,
    output logic [2:0]          imm_sel,
    output logic [1:0]          alu_a_sel,
    output logic [1:0]          alu_b_sel,
    output logic [2:0]          alu_op,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic                illegal
);

    state_t state_q;
    state_t state_d;
    dec_t   cls;

    mc_decode u_decode (
        .instr (instr),
        .cls   (cls)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (cls.is_illegal)  state_d = S_HALT;
                else if (cls.is_beq) state_d = S_BRANCH;
                else if (cls.is_jal) state_d = S_JUMP;
                else                 state_d = S_EXEC;
            end
            S_EXEC:   state_d = is_mem_op(cls) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack) state_d = cls.is_lw ? S_WB : S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        imm_sel      = IMM_I;
        alu_a_sel    = A_PC;
        alu_b_sel    = B_RS2;
        alu_op       = ALU_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU_R;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = A_PC;
                alu_b_sel = B_FOUR;
                alu_op    = ALU_ADD;
                // IR and PC load together on the accepted fetch.
                ir_we     = mem_ack;
                pc_we     = mem_ack;
                pc_src    = 1'b0;
            end
            S_DECODE: begin
                // Branch target is precomputed while decoding.
                imm_sel   = IMM_B;
                alu_a_sel = A_OLD_PC;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                if (cls.is_r) begin
                    alu_a_sel = A_RS1;
                    alu_b_sel = B_RS2;
                    alu_op    = ALU_FUNCT;
                end else if (cls.is_lui) begin
                    imm_sel   = IMM_U;
                    alu_a_sel = A_ZERO;
                    alu_b_sel = B_IMM;
                end else if (cls.is_sw) begin
                    imm_sel   = IMM_S;
                    alu_a_sel = A_RS1;
                    alu_b_sel = B_IMM;
                end else begin
                    imm_sel   = IMM_I;
                    alu_a_sel = A_RS1;
                    alu_b_sel = B_IMM;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = cls.is_sw;
                // A store completes on its acknowledge.
                retire       = cls.is_sw & mem_ack;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = cls.is_lw ? WB_MEM : WB_ALU_R;
                retire = 1'b1;
            end
            S_BRANCH: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_RS2;
                alu_op    = ALU_SUB;
                pc_we     = zero;
                pc_src    = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                imm_sel   = IMM_J;
                alu_a_sel = A_OLD_PC;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
                pc_we     = 1'b1;
                pc_src    = 1'b0;
                // Link value comes from the dedicated old-PC+4 path.
                rf_we     = 1'b1;
                wb_sel    = WB_PC4;
                retire    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    // Only a reset clears it; HALT is absorbing anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (state_q == S_DECODE && cls.is_illegal) begin
            illegal <= 1'b1;
        end
    end

endmodule
